ita_output_buffer: RTL
======================

Name: ita_output_buffer

Overview:
- Sits directly downstream of the ITA controller and requantization datapath.
- Captures each finished output beat produced on a last inner tile.
- Buffers beats in a first-word-fall-through FIFO of depth FifoDepth and presents them on a valid/ready output port.
- Tags each beat with its step and its position within the output tile; its pop handshake is the oup_valid/oup_ready pair the controller uses for in-flight accounting.

Parameters:
- N, 16, number of output lanes per beat.
- M, 64, tile edge; beats per output tile = M*M/N (256 at defaults).
- WO, 8, bits per output lane after requantization.
- FifoDepth, 4, number of buffered beats; must be ≥2 and a power of two.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- clear_i  in  1  synchronous flush
- step_i  in  step_e  current controller step, sampled on push
- res_valid_i  in  1  requantized beat valid (push request)
- res_data_i  in  N*WO  requantized beat
- oup_data_o  out  N*WO  head beat
- oup_step_o  out  step_e  step tag of head beat
- oup_idx_o  out  $clog2(M*M/N)  beat index of head within its output tile
- oup_last_o  out  1  head is the final beat of its tile
- oup_valid_o  out  1  head valid
- oup_ready_i  in  1  consumer accepts head
- fill_o  out  $clog2(FifoDepth)+1  current occupancy
- busy_o  out  1  buffer non-empty
- overflow_o  out  1  sticky: push dropped while full

Interface decision: one clock; reset is asynchronous and active-low (clk_i, rst_ni).

Behaviour:
- Reset: FIFO empty, fill_o=0, oup_valid_o=0, busy_o=0, overflow_o=0, oup_idx_o=0, oup_last_o=0, oup_data_o=0, oup_step_o=Idle.
- Push: occurs on a cycle with res_valid_i=1. It stores {res_data_i, step_i} at the write pointer.
  - No ready is returned upstream; the controller's ongoing counter guarantees space.
- Pop: occurs on a cycle with oup_valid_o && oup_ready_i. It advances the read pointer.
  - oup_data_o and oup_step_o are FWFT: they show the head entry combinationally from the storage registers.
  - Zero-cycle bubble between consecutive pops.
- Latency: a beat pushed in cycle t is visible with oup_valid_o=1 in cycle t+1. There is no same-cycle bypass when empty.
- oup_valid_o = (fill_o != 0); busy_o = oup_valid_o.
- Simultaneous push and pop:
  - Always accepted, including when full.
  - fill unchanged.
  - When fill=1, the old head pops and the new beat becomes head in the next cycle.
- Push while full without pop:
  - Beat dropped, storage unchanged.
  - overflow_o set in the next cycle and held until clear_i or reset.
- Pop while empty: impossible because oup_valid_o=0; ready is ignored.
- Tile index counter:
  - Advances by 1 on every pop and wraps from M*M/N-1 to 0.
  - oup_idx_o = counter value; oup_last_o = oup_valid_o && counter == M*M/N-1.
  - The counter also resets to 0 whenever the head step tag differs from the tag of the previously popped beat. This is evaluated at pop, so a step change always starts at index 0.
- clear_i:
  - Highest priority: empties the FIFO, zeroes the pointers, the fill count and the tile counter, and clears overflow_o.
  - Any push or pop in the same cycle is discarded.
  - Outputs show the reset values next cycle.
- Async reset mid-operation: all state returns to its reset value immediately; buffered beats are lost.
- Widths: pointers are $clog2(FifoDepth) bits and wrap naturally. The fill counter is one bit wider so it can hold FifoDepth exactly.

Decomposition:
- In ita_package:
  - step_e (already exists).
  - An oup_beat_t struct {data N*WO, step step_e}.
  - OupIdxWidth = $clog2(M*M/N).
  - Reuse the existing N, M, WO, FifoDepth constants.
- One sub-module, ita_fifo_fwft, parameterised on a generic type and depth: storage, pointers, fill, full/empty.
- The top level adds the tile counter, the step-change detection and the sticky overflow flag.

Test Plan:
1. Reset then idle: after rst_ni release with no push, oup_valid_o=0, fill_o=0, overflow_o=0, oup_step_o=Idle.
2. Fill/drain: push 4 beats with data 1..4, step QK, oup_ready_i=0. Expect fill_o=4. Then ready=1 for 4 cycles: data 1,2,3,4 in order, oup_idx_o 0,1,2,3, fill_o returns to 0.
3. Full + push + pop: at fill=4, push beat 5 with oup_ready_i=1. Expect fill stays 4, overflow_o=0, beat 5 emitted after beats 2..4.
4. Overflow: at fill=4 with ready=0, push beat 9. Expect overflow_o=1 from the next cycle, beat 9 never emitted. Assert clear_i: overflow_o=0 and fill_o=0 next cycle.
5. Tile wrap/step change: stream 256 beats of step Q with ready=1. Expect oup_last_o=1 only on the beat with oup_idx_o=255, then the next Q beat has idx 0. Push a K beat after 10 Q beats: the K beat pops with idx 0.
6. clear_i priority: in a cycle with res_valid_i=1, oup_ready_i=1, fill=2, assert clear_i. Expect fill_o=0 and oup_valid_o=0 next cycle, with no beat emitted in the clear cycle counted.

Source files
------------

// File: rtl/ita_package.sv
// Shared ITA constants and types used by the output buffer and its FIFO.
package ita_package;

  localparam int unsigned N           = 16;
  localparam int unsigned M           = 64;
  localparam int unsigned WO          = 8;
  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned OupIdxWidth = $clog2(M * M / N);
  localparam int unsigned FillWidth   = $clog2(FifoDepth) + 1;

  typedef enum logic [3:0] {
    Idle, Q, K, V, QK, AV, OW, F1, F2, MatMul
  } step_e;

  typedef struct packed {
    logic [N*WO-1:0] data;
    step_e           step;
  } oup_beat_t;

endpackage

// File: rtl/ita_fifo_fwft.sv
// First-word-fall-through FIFO; push while full is accepted only alongside a pop.
module ita_fifo_fwft #(
  parameter type         beat_t = logic,
  parameter int unsigned Depth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  beat_t                data_i,
  input  logic                 pop_i,
  output beat_t                data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [$clog2(Depth):0] fill_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  beat_t           mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   fill_q;
  logic            push_ok, pop_ok;

  // Depth is a power of two, so the fill MSB alone marks full.
  assign full_o  = fill_q[PtrW];
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Empty head reads as all-zero so outputs match their reset values.
  assign data_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!clear_i && push_ok) mem_q[wptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      fill_q <= fill_q + (PtrW+1)'(1);
      else if (pop_ok && !push_ok) fill_q <= fill_q - (PtrW+1)'(1);
    end
  end

endmodule

// File: rtl/ita_output_buffer.sv
// Output beat buffer: FWFT queue plus tile-position tagging and sticky overflow.
module ita_output_buffer
  import ita_package::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  step_e                  step_i,
  input  logic                   res_valid_i,
  input  logic [N*WO-1:0]        res_data_i,
  output logic [N*WO-1:0]        oup_data_o,
  output step_e                  oup_step_o,
  output logic [OupIdxWidth-1:0] oup_idx_o,
  output logic                   oup_last_o,
  output logic                   oup_valid_o,
  input  logic                   oup_ready_i,
  output logic [FillWidth-1:0]   fill_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam logic [OupIdxWidth-1:0] LastIdx = OupIdxWidth'(M * M / N - 1);

  oup_beat_t              push_beat, head_beat;
  logic                   full, empty, pop;
  logic [OupIdxWidth-1:0] cnt_q;
  step_e                  last_step_q;
  logic                   overflow_q;

  assign push_beat = '{data: res_data_i, step: step_i};

  ita_fifo_fwft #(
    .beat_t (oup_beat_t),
    .Depth  (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (res_valid_i),
    .data_i  (push_beat),
    .pop_i   (pop),
    .data_o  (head_beat),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill_o)
  );

  assign oup_valid_o = !empty;
  assign busy_o      = oup_valid_o;
  assign pop         = oup_valid_o && oup_ready_i;
  assign oup_data_o  = head_beat.data;
  assign oup_step_o  = head_beat.step;
  assign overflow_o  = overflow_q;

  // A head whose step differs from the last popped beat starts a new tile.
  assign oup_idx_o  = (head_beat.step != last_step_q) ? '0 : cnt_q;
  assign oup_last_o = oup_valid_o && (oup_idx_o == LastIdx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      last_step_q <= Idle;
      overflow_q  <= 1'b0;
    end else if (clear_i) begin
      cnt_q       <= '0;
      last_step_q <= Idle;
      overflow_q  <= 1'b0;
    end else begin
      if (pop) begin
        cnt_q       <= (oup_idx_o == LastIdx) ? '0 : oup_idx_o + OupIdxWidth'(1);
        last_step_q <= head_beat.step;
      end
      if (res_valid_i && full && !pop) overflow_q <= 1'b1;
    end
  end

endmodule
